// File: rtl/dso_pkg.sv
// dso_pkg: shared capture types and sample RAM geometry for DSO_dig
package dso_pkg;
  localparam int ENTRIES = 512;
  localparam int AW = $clog2(ENTRIES);
  typedef enum logic [1:0] {TRIG_OFF = 2'b00, TRIG_NORM = 2'b01, TRIG_ROLL = 2'b10} trig_type_t;
  typedef enum logic [2:0] {IDLE, ARMING, WAIT_TRIG, POST, ROLL, DONE} cap_state_t;
endpackage

// File: rtl/smpl_decimator.sv
// smpl_decimator: keeps 1 of every 2^decimator ADC sample strobes
module smpl_decimator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       smpl_vld,
  input  logic [3:0] decimator,
  input  logic       clr,
  output logic       smpl_q
);
  logic [15:0] cnt;
  logic [15:0] lim;
  assign lim = 16'((17'd1 << decimator) - 17'd1);
  assign smpl_q = smpl_vld && cnt == lim;
  // prescale counter restarts after each qualified strobe or when capture is idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (smpl_vld) cnt <= smpl_q ? '0 : cnt + 16'd1;
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: circular sample RAM write sequencer with pre/post trigger windows
module capture_ctrl import dso_pkg::*; #(
  parameter int ENTRIES = dso_pkg::ENTRIES,
  parameter int AW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          smpl_vld,
  input  logic [3:0]    decimator,
  input  logic [1:0]    trig_type,
  input  logic [AW-1:0] trig_pos,
  input  logic          triggered,
  input  logic          clr_cap_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] trace_end,
  output logic          armed,
  output logic          capture_done
);
  cap_state_t state;
  logic smpl_q;
  logic writing;
  logic trig_off;
  logic [AW:0] cnt;
  logic [AW:0] cnt_inc;
  logic [AW:0] arm_lvl;
  smpl_decimator u_dec (
    .clk(clk),
    .rst_n(rst_n),
    .smpl_vld(smpl_vld),
    .decimator(decimator),
    .clr(state == IDLE || state == DONE),
    .smpl_q(smpl_q)
  );
  assign writing = state == ARMING || state == WAIT_TRIG || state == POST || state == ROLL;
  assign we = smpl_q && writing && !(state == WAIT_TRIG && triggered && trig_pos == '0);
  assign trig_off = trig_type[0] == trig_type[1];
  assign cnt_inc = cnt + (AW+1)'(we);
  assign arm_lvl = (AW+1)'(ENTRIES) - (AW+1)'(trig_pos);
  // capture sequencer: address generation, sample counting and state transitions
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      waddr <= '0;
      trace_end <= '0;
      armed <= 1'b0;
      capture_done <= 1'b0;
      cnt <= '0;
    end else begin
      if (we) begin
        waddr <= waddr + 1'b1;
        trace_end <= waddr;
      end
      if (trig_off) begin
        state <= IDLE;
        armed <= 1'b0;
        capture_done <= 1'b0;
      end else
        case (state)
          IDLE: begin
            cnt <= '0;
            state <= trig_type == TRIG_NORM ? ARMING : ROLL;
          end
          ARMING: begin
            cnt <= cnt_inc;
            if (we && cnt_inc == arm_lvl) begin
              state <= WAIT_TRIG;
              armed <= 1'b1;
            end
          end
          WAIT_TRIG:
            if (triggered) begin
              armed <= 1'b0;
              cnt <= (AW+1)'(we);
              if (trig_pos == '0 || (we && trig_pos == AW'(1))) begin
                state <= DONE;
                capture_done <= 1'b1;
              end else state <= POST;
            end
          POST: begin
            cnt <= cnt_inc;
            if (we && cnt_inc == (AW+1)'(trig_pos)) begin
              state <= DONE;
              capture_done <= 1'b1;
            end
          end
          ROLL: if (trig_type != TRIG_ROLL) state <= IDLE;
          DONE:
            if (clr_cap_done) begin
              state <= IDLE;
              capture_done <= 1'b0;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed vector bench for the capture sequencer
module tb_capture_ctrl;
  import dso_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic smpl_vld = 1'b0;
  logic triggered = 1'b0;
  logic clr_cap_done = 1'b0;
  logic [3:0] decimator = '0;
  logic [1:0] trig_type = 2'b00;
  logic [AW-1:0] trig_pos = '0;
  logic we, armed, capture_done;
  logic [AW-1:0] waddr, trace_end;
  int n_cmp = 0;
  int n_bad = 0;
  int wr = 0;
  int base = 0;

  typedef struct {
    int dec;
    int tp;
    int extra;
    int arm_p;
    int extra_w;
    int post_p;
    int total;
  } vec_t;
  vec_t vecs[4];

  capture_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .smpl_vld(smpl_vld),
    .decimator(decimator),
    .trig_type(trig_type),
    .trig_pos(trig_pos),
    .triggered(triggered),
    .clr_cap_done(clr_cap_done),
    .we(we),
    .waddr(waddr),
    .trace_end(trace_end),
    .armed(armed),
    .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one sample strobe then one idle cycle; counts writes seen in the strobe cycle
  task automatic pulse(input logic trig);
    @(posedge clk);
    #1 smpl_vld = 1'b1;
    triggered = trig;
    @(negedge clk);
    if (we) wr++;
    @(posedge clk);
    #1 smpl_vld = 1'b0;
    triggered = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int p;
    logic bad;
    vecs[0] = '{0, 308, 5, 204, 5, 308, 517};
    vecs[1] = '{2, 8, 3, 2016, 0, 29, 512};
    vecs[2] = '{0, 0, 2, 512, 2, 1, 514};
    vecs[3] = '{1, 1, 1, 1022, 0, 1, 512};
    repeat (2) @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_trace_end", trace_end, 0);
    chk("rst_armed", armed, 0);
    chk("rst_done", capture_done, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 trig_type = 2'b10;
    wr = 0;
    bad = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      pulse(1'b0);
      if (armed || capture_done) bad = 1'b1;
    end
    chk("roll_writes", wr, 1100);
    chk("roll_flags", bad, 0);
    chk("roll_waddr", waddr, 76);
    chk("roll_trace_end", trace_end, 75);
    @(posedge clk);
    #1 trig_type = 2'b00;
    @(posedge clk);
    #1 smpl_vld = 1'b1;
    @(negedge clk);
    chk("roll_off_we", we, 0);
    @(posedge clk);
    #1 smpl_vld = 1'b0;
    base = 76;
    foreach (vecs[i]) begin
      @(posedge clk);
      #1 trig_type = 2'b00;
      decimator = 4'(vecs[i].dec);
      trig_pos = AW'(vecs[i].tp);
      @(posedge clk);
      #1 trig_type = 2'b01;
      wr = 0;
      p = 0;
      while (!armed && p < 5000) begin
        pulse(p == 2);
        p++;
        if (p == 3) chk($sformatf("v%0d_early_trig", i), {armed, capture_done}, 0);
      end
      chk($sformatf("v%0d_arm_pulses", i), p, vecs[i].arm_p);
      chk($sformatf("v%0d_arm_writes", i), wr, 512 - vecs[i].tp);
      wr = 0;
      repeat (vecs[i].extra) pulse(1'b0);
      chk($sformatf("v%0d_wait_writes", i), wr, vecs[i].extra_w);
      wr = 0;
      p = 0;
      while (!capture_done && p < 5000) begin
        pulse(p == 0);
        p++;
      end
      chk($sformatf("v%0d_post_pulses", i), p, vecs[i].post_p);
      chk($sformatf("v%0d_post_writes", i), wr, vecs[i].tp);
      chk($sformatf("v%0d_armed_drop", i), armed, 0);
      base = (base + vecs[i].total) % 512;
      chk($sformatf("v%0d_waddr", i), waddr, base);
      chk($sformatf("v%0d_trace_end", i), trace_end, (base + 511) % 512);
    end
    bad = 1'b0;
    @(posedge clk);
    #1 smpl_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (we) bad = 1'b1;
    end
    @(posedge clk);
    #1 smpl_vld = 1'b0;
    chk("done_no_write", bad, 0);
    chk("done_waddr_frozen", waddr, base);
    chk("done_held", capture_done, 1);
    decimator = 4'd0;
    trig_pos = AW'(4);
    clr_cap_done = 1'b1;
    @(posedge clk);
    #1 clr_cap_done = 1'b0;
    @(negedge clk);
    chk("clr_done", capture_done, 0);
    wr = 0;
    pulse(1'b0);
    chk("rearm_write", wr, 1);
    p = 0;
    while (!armed && p < 1000) begin
      pulse(1'b0);
      p++;
    end
    chk("rearm_writes", wr, 508);
    pulse(1'b1);
    pulse(1'b0);
    chk("post_not_done", capture_done, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    smpl_vld = 1'b1;
    #1;
    chk("arst_we", we, 0);
    chk("arst_waddr", waddr, 0);
    chk("arst_trace_end", trace_end, 0);
    chk("arst_flags", {armed, capture_done}, 0);
    smpl_vld = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
